// File: rtl/mem_pkg.sv
// Shared constants and encodings for the block-copy engine and its 128x8 memory.
package mem_pkg;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_copy.sv
// Block copy / constant fill engine driving a single-port memory with a one-cycle registered read.
module mem_block_copy #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  import mem_pkg::*;

  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_C = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q;
  logic              busy_q, done_q, ren_q, wen_q, desc_q;
  logic [ADDR_W-1:0] addr_q, src_ptr_q, dst_ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] pat_q;

  logic [ADDR_W-1:0] dist_d, len_m1_d, src_first_d, dst_first_d, src_step_d, dst_step_d;
  logic [ADDR_W:0]   cnt_dec_d;
  logic              desc_d, last_d;

  // Destination ahead of source inside the window: copy from the top end down.
  assign dist_d      = dst - src;
  assign desc_d      = (dist_d != '0) && ({1'b0, dist_d} < len);
  assign len_m1_d    = len[ADDR_W-1:0] - ONE_A;
  assign src_first_d = desc_d ? (src + len_m1_d) : src;
  assign dst_first_d = desc_d ? (dst + len_m1_d) : dst;
  assign src_step_d  = desc_q ? (src_ptr_q - ONE_A) : (src_ptr_q + ONE_A);
  assign dst_step_d  = desc_q ? (dst_ptr_q - ONE_A) : (dst_ptr_q + ONE_A);
  assign cnt_dec_d   = cnt_q - ONE_C;
  assign last_d      = (cnt_q == ONE_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      desc_q    <= 1'b0;
      addr_q    <= '0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      pat_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q  <= len;
            pat_q  <= pattern;
            busy_q <= 1'b1;
            if (len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (mode == MODE_FILL) begin
              state_q   <= ST_FILL;
              desc_q    <= 1'b0;
              dst_ptr_q <= dst;
              wen_q     <= 1'b1;
              addr_q    <= dst;
            end else begin
              state_q   <= ST_READ;
              desc_q    <= desc_d;
              src_ptr_q <= src_first_d;
              dst_ptr_q <= dst_first_d;
              ren_q     <= 1'b1;
              addr_q    <= src_first_d;
            end
          end
        end
        ST_READ: begin
          state_q <= ST_WRITE;
          ren_q   <= 1'b0;
          wen_q   <= 1'b1;
          addr_q  <= dst_ptr_q;
        end
        ST_WRITE: begin
          src_ptr_q <= src_step_d;
          dst_ptr_q <= dst_step_d;
          cnt_q     <= cnt_dec_d;
          wen_q     <= 1'b0;
          if (last_d) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            addr_q  <= '0;
          end else begin
            state_q <= ST_READ;
            ren_q   <= 1'b1;
            addr_q  <= src_step_d;
          end
        end
        ST_FILL: begin
          dst_ptr_q <= dst_step_d;
          cnt_q     <= cnt_dec_d;
          if (last_d) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            wen_q   <= 1'b0;
            addr_q  <= '0;
          end else begin
            addr_q <= dst_step_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
          addr_q  <= '0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_ren  = ren_q;
  assign mem_wen  = wen_q;
  assign mem_addr = addr_q;
  // Read data flows straight from the memory's output register into the write port.
  assign mem_din  = (state_q == ST_WRITE) ? mem_dout :
                    (state_q == ST_FILL)  ? pat_q    : '0;

endmodule

// File: tb/tb_mem_block_copy.sv
// Directed bench for mem_block_copy with a behavioural 128x8 registered-read memory beside it.
module tb_mem_block_copy;
  import mem_pkg::*;

  logic       clk, rst, start, mode;
  logic [6:0] src, dst;
  logic [7:0] len, pattern;
  logic       busy, done, mem_ren, mem_wen;
  logic [6:0] mem_addr;
  logic [7:0] mem_din, mem_dout;

  logic [7:0] mem [0:127];
  logic       tb_we;
  logic [6:0] tb_addr;
  logic [7:0] tb_data;

  int n_checks = 0;
  int n_errors = 0;

  logic       tr_ren [0:63];
  logic       tr_wen [0:63];
  logic       tr_busy[0:63];
  logic [6:0] tr_addr[0:63];
  logic [7:0] tr_din [0:63];
  int         done_cyc, wen_count;

  mem_block_copy #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .pattern(pattern), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_dout <= mem_ren ? mem[mem_addr] : 8'h00;
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_wen && !mem_ren) mem[mem_addr] <= mem_din;
  end

  task automatic poke(input logic [6:0] a, input logic [7:0] v);
    tb_we = 1'b1; tb_addr = a; tb_data = v;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) poke(7'(i), 8'h00);
  endtask

  // Issues one command at the current negedge and traces cycles 1..done+1.
  task automatic run_cmd(input logic m, input logic [6:0] s, input logic [6:0] d,
                         input logic [7:0] l, input logic [7:0] p, input int restart_at);
    start = 1'b1; mode = m; src = s; dst = d; len = l; pattern = p;
    done_cyc = 0; wen_count = 0;
    for (int c = 1; c < 64; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (c == restart_at) begin
        mode = MODE_COPY; src = 7'd0; dst = 7'd90; len = 8'd5;
      end
      tr_ren[c] = mem_ren; tr_wen[c] = mem_wen; tr_busy[c] = busy;
      tr_addr[c] = mem_addr; tr_din[c] = mem_din;
      if (mem_wen) wen_count++;
      if (done && done_cyc == 0) done_cyc = c;
      if (done_cyc != 0 && c == done_cyc + 1) break;
    end
    start = 1'b0;
    $display("cmd mode=%0d src=%0d dst=%0d len=%0d pat=%h -> done_cycle=%0d writes=%0d",
             m, s, d, l, p, done_cyc, wen_count);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode = MODE_FILL; len = 8'd3;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin n_errors++; $display("FAIL reset_en: got ren=%b wen=%b want 0/0", mem_ren, mem_wen); end
    n_checks++; if (mem_addr !== 7'd0 || mem_din !== 8'd0) begin n_errors++; $display("FAIL reset_bus: got addr=%0d din=%h want 0/00", mem_addr, mem_din); end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_fill();
    run_cmd(MODE_FILL, 7'd0, 7'd10, 8'd4, 8'hA5, 0);
    n_checks++; if (done_cyc !== 5) begin n_errors++; $display("FAIL fill_done_cycle: got %0d want 5", done_cyc); end
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (tr_wen[c] !== 1'b1 || tr_ren[c] !== 1'b0 || tr_addr[c] !== 7'(9 + c) || tr_din[c] !== 8'hA5) begin
        n_errors++;
        $display("FAIL fill_cycle%0d: got wen=%b ren=%b addr=%0d din=%h want 1/0/%0d/a5",
                 c, tr_wen[c], tr_ren[c], tr_addr[c], tr_din[c], 9 + c);
      end
    end
    n_checks++; if (tr_busy[6] !== 1'b0 || tr_din[6] !== 8'h00) begin n_errors++; $display("FAIL fill_idle_after: got busy=%b din=%h want 0/00", tr_busy[6], tr_din[6]); end
    for (int a = 10; a <= 13; a++) begin
      n_checks++; if (mem[a] !== 8'hA5) begin n_errors++; $display("FAIL fill_mem[%0d]: got %h want a5", a, mem[a]); end
    end
    n_checks++; if (mem[14] !== 8'h00) begin n_errors++; $display("FAIL fill_mem[14]: got %h want 00", mem[14]); end
  endtask

  task automatic test_copy_asc();
    logic [6:0] ea [1:6];
    logic       er;
    ea = '{7'd20, 7'd40, 7'd21, 7'd41, 7'd22, 7'd42};
    poke(7'd20, 8'd1); poke(7'd21, 8'd2); poke(7'd22, 8'd3);
    run_cmd(MODE_COPY, 7'd20, 7'd40, 8'd3, 8'h00, 0);
    n_checks++; if (done_cyc !== 7) begin n_errors++; $display("FAIL asc_done_cycle: got %0d want 7", done_cyc); end
    for (int c = 1; c <= 6; c++) begin
      er = (c % 2) == 1;
      n_checks++;
      if (tr_addr[c] !== ea[c] || tr_ren[c] !== er || tr_wen[c] !== !er) begin
        n_errors++;
        $display("FAIL asc_cycle%0d: got addr=%0d ren=%b wen=%b want %0d/%b/%b",
                 c, tr_addr[c], tr_ren[c], tr_wen[c], ea[c], er, !er);
      end
      if (!er) begin
        n_checks++; if (tr_din[c] !== 8'(c / 2)) begin n_errors++; $display("FAIL asc_din%0d: got %h want %h", c, tr_din[c], 8'(c / 2)); end
      end
    end
    for (int a = 40; a <= 42; a++) begin
      n_checks++; if (mem[a] !== 8'(a - 39)) begin n_errors++; $display("FAIL asc_mem[%0d]: got %h want %h", a, mem[a], 8'(a - 39)); end
    end
  endtask

  task automatic test_overlap();
    logic [7:0] ev [2:5];
    ev = '{8'd9, 8'd8, 8'd7, 8'd6};
    poke(7'd0, 8'd9); poke(7'd1, 8'd8); poke(7'd2, 8'd7); poke(7'd3, 8'd6);
    run_cmd(MODE_COPY, 7'd0, 7'd2, 8'd4, 8'h00, 0);
    n_checks++; if (done_cyc !== 9) begin n_errors++; $display("FAIL ovl_done_cycle: got %0d want 9", done_cyc); end
    n_checks++; if (tr_addr[1] !== 7'd3 || tr_addr[2] !== 7'd5) begin n_errors++; $display("FAIL ovl_first_addrs: got %0d,%0d want 3,5", tr_addr[1], tr_addr[2]); end
    for (int a = 2; a <= 5; a++) begin
      n_checks++; if (mem[a] !== ev[a]) begin n_errors++; $display("FAIL ovl_mem[%0d]: got %h want %h", a, mem[a], ev[a]); end
    end
    // Destination behind source: must stay ascending.
    poke(7'd60, 8'd11); poke(7'd61, 8'd12); poke(7'd62, 8'd13); poke(7'd63, 8'd14);
    run_cmd(MODE_COPY, 7'd61, 7'd60, 8'd3, 8'h00, 0);
    n_checks++; if (tr_addr[1] !== 7'd61) begin n_errors++; $display("FAIL behind_first_addr: got %0d want 61", tr_addr[1]); end
    for (int a = 60; a <= 62; a++) begin
      n_checks++; if (mem[a] !== 8'(a - 48)) begin n_errors++; $display("FAIL behind_mem[%0d]: got %h want %h", a, mem[a], 8'(a - 48)); end
    end
  endtask

  task automatic test_wrap();
    logic [6:0] ea [1:4];
    ea = '{7'd126, 7'd127, 7'd0, 7'd1};
    run_cmd(MODE_FILL, 7'd0, 7'd126, 8'd4, 8'h3C, 0);
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if (tr_addr[c] !== ea[c]) begin n_errors++; $display("FAIL wrap_addr%0d: got %0d want %0d", c, tr_addr[c], ea[c]); end
      n_checks++; if (mem[ea[c]] !== 8'h3C) begin n_errors++; $display("FAIL wrap_mem[%0d]: got %h want 3c", ea[c], mem[ea[c]]); end
    end
  endtask

  task automatic test_len_zero();
    run_cmd(MODE_COPY, 7'd5, 7'd6, 8'd0, 8'h00, 0);
    n_checks++; if (done_cyc !== 1) begin n_errors++; $display("FAIL len0_done_cycle: got %0d want 1", done_cyc); end
    n_checks++; if (wen_count !== 0 || tr_ren[1] !== 1'b0) begin n_errors++; $display("FAIL len0_access: got writes=%0d ren=%b want 0/0", wen_count, tr_ren[1]); end
    n_checks++; if (tr_busy[1] !== 1'b1 || tr_busy[2] !== 1'b0) begin n_errors++; $display("FAIL len0_busy: got %b,%b want 1,0", tr_busy[1], tr_busy[2]); end
  endtask

  task automatic test_start_busy();
    run_cmd(MODE_FILL, 7'd0, 7'd70, 8'd3, 8'h11, 2);
    n_checks++; if (done_cyc !== 4 || wen_count !== 3) begin n_errors++; $display("FAIL busy_start_run: got done=%0d writes=%0d want 4/3", done_cyc, wen_count); end
    n_checks++; if (mem[72] !== 8'h11 || mem[73] !== 8'h00) begin n_errors++; $display("FAIL busy_start_mem: got %h,%h want 11,00", mem[72], mem[73]); end
    n_checks++; if (mem[90] !== 8'h00 || tr_busy[5] !== 1'b0) begin n_errors++; $display("FAIL busy_start_ignored: got mem90=%h busy=%b want 00/0", mem[90], tr_busy[5]); end
  endtask

  task automatic test_back_to_back();
    run_cmd(MODE_FILL, 7'd0, 7'd100, 8'd2, 8'h55, 0);
    run_cmd(MODE_FILL, 7'd0, 7'd102, 8'd2, 8'h66, 0);
    n_checks++; if (done_cyc !== 3 || tr_addr[1] !== 7'd102) begin n_errors++; $display("FAIL b2b_second: got done=%0d addr=%0d want 3/102", done_cyc, tr_addr[1]); end
    n_checks++;
    if (mem[100] !== 8'h55 || mem[101] !== 8'h55 || mem[102] !== 8'h66 || mem[103] !== 8'h66) begin
      n_errors++;
      $display("FAIL b2b_mem: got %h %h %h %h want 55 55 66 66", mem[100], mem[101], mem[102], mem[103]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) poke(7'(30 + i), 8'(8'h31 + i));
    start = 1'b1; mode = MODE_COPY; src = 7'd30; dst = 7'd80; len = 8'd8;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 6) rst = 1'b1;
      if (c == 7) begin
        n_checks++; if (busy !== 1'b0 || mem_wen !== 1'b0) begin n_errors++; $display("FAIL rstmid_ctrl: got busy=%b wen=%b want 0/0", busy, mem_wen); end
        n_checks++; if (mem_ren !== 1'b0 || mem_addr !== 7'd0) begin n_errors++; $display("FAIL rstmid_bus: got ren=%b addr=%0d want 0/0", mem_ren, mem_addr); end
      end
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("cmd reset mid-copy src=30 dst=80 len=8");
    n_checks++; if (mem[80] !== 8'h31 || mem[81] !== 8'h32) begin n_errors++; $display("FAIL rstmid_head: got %h,%h want 31,32", mem[80], mem[81]); end
    for (int a = 83; a <= 87; a++) begin
      n_checks++; if (mem[a] !== 8'h00) begin n_errors++; $display("FAIL rstmid_tail[%0d]: got %h want 00", a, mem[a]); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; pattern = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    @(negedge clk);
    test_reset();
    clear_mem();
    test_fill();
    test_copy_asc();
    test_overlap();
    test_wrap();
    test_len_zero();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_block_copy.md
# mem_block_copy

Command-driven block-transfer engine that sits directly upstream of the 128×8 `Memory` and owns its `ren`/`wen`/`addr`/`din` port. It performs either a byte copy from one region to another or a constant fill, using the memory's one-cycle registered read. The block signals busy and done to the controlling logic.

## Interface
Parameters:
- `ADDR_W`, 7: memory address width (128 entries).
- `DATA_W`, 8: memory data width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state updates on posedge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; sampled with `start`.
- `src`  in  ADDR_W  copy source base; sampled with `start`.
- `dst`  in  ADDR_W  destination base; sampled with `start`.
- `len`  in  ADDR_W+1  byte count, 0..128; sampled with `start`.
- `pattern`  in  DATA_W  fill value; sampled with `start`.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse in the DONE state.
- `mem_ren`  out  1  to Memory `ren`.
- `mem_wen`  out  1  to Memory `wen`.
- `mem_addr`  out  ADDR_W  to Memory `addr`.
- `mem_din`  out  DATA_W  to Memory `din`.
- `mem_dout`  in  DATA_W  from Memory `dout`.

## Operation
- Memory contract:
  - `ren` high: `dout` loads `mem[addr]` at the posedge.
  - `ren` low: `dout` loads 0.
  - A write occurs only when `wen && !ren`.
- States: IDLE, READ, WRITE, FILL, DONE.
- IDLE:
  - `start` high with `len`==0: go to DONE.
  - `start` high, mode 0: go to READ.
  - `start` high, mode 1: go to FILL.
  - Command fields are latched into internal registers when `start` is accepted.
- READ: `mem_ren`=1, `mem_wen`=0, `mem_addr`=current source pointer. Next state is WRITE.
- WRITE:
  - Drives `mem_ren`=0, `mem_wen`=1, `mem_addr`=current destination pointer, `mem_din`=`mem_dout` (combinational pass-through).
  - Steps both pointers and decrements the remaining count.
  - Next state is READ if bytes remain, else DONE.
- FILL:
  - Drives `mem_wen`=1, `mem_ren`=0, `mem_addr`=destination pointer, `mem_din`=latched `pattern`.
  - Steps the pointer each cycle; goes to DONE after the last byte.
- DONE: `done`=1, `busy`=1; next state is IDLE.
- Direction rule (copy only):
  - Compute d = (dst − src) mod 128.
  - If 1 ≤ d < len, the regions overlap with the destination ahead of the source. The copy then runs descending: pointers start at base+len−1 and decrement.
  - Otherwise the copy runs ascending from the bases.
  - Fill is always ascending.
- Pointer arithmetic is ADDR_W bits and wraps modulo 128 in both directions. Example: address 127+1 → 0.
- `start` outside IDLE is ignored; the in-flight command is unaffected.
- Outputs in IDLE and DONE: `mem_ren`=`mem_wen`=0, `mem_addr`=0, `mem_din`=0.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `mem_ren`=0, `mem_wen`=0, `mem_addr`=0, `mem_din`=0; all internal registers 0.
- `rst` mid-operation: at the next posedge the block returns to IDLE with the reset values above. Any partial transfer is abandoned and no further write is issued.
- Latency, with `start` accepted at posedge 0:
  - Copy: first READ during cycle 1; 2·len cycles of READ/WRITE; DONE in cycle 2·len+1; IDLE in cycle 2·len+2.
  - Fill: len FILL cycles; DONE in cycle len+1.
  - len = 0: DONE in cycle 1, with no memory access.
- The earliest next `start` is accepted in the first IDLE cycle after DONE.
- `mem_din` in WRITE equals the `mem_dout` registered at the end of the preceding READ cycle.

## Structure
- Shared package/header `mem_pkg`:
  - `ADDR_W`=7, `DATA_W`=8, `MEM_DEPTH`=128.
  - State encoding constants (IDLE=0, READ=1, WRITE=2, FILL=3, DONE=4).
  - Mode constants `MODE_COPY`=0, `MODE_FILL`=1.
- No sub-module inside this block.
- `Memory` is instantiated as a sibling at the top level, wired port-to-port to the `mem_*` signals.

## Test plan
- Fill: start mode=1, dst=10, len=4, pattern=8'hA5 → four writes to 10..13 in cycles 1–4; `done` pulse in cycle 5; readback of 10..13 = A5.
- Ascending copy: preload 20..22 = 1,2,3; start mode=0, src=20, dst=40, len=3 → `mem_addr` sequence 20,40,21,41,22,42; 40..42 = 1,2,3; `done` in cycle 7.
- Overlap descending: preload 0..3 = 9,8,7,6; copy src=0, dst=2, len=4 → first READ at addr 3; final 2..5 = 9,8,7,6.
- Wrap-around: fill dst=126, len=4, pattern=8'h3C → writes to 126,127,0,1.
- Boundary: len=0 → `done` in cycle 1, no `mem_wen`. Start while busy is ignored.
- Reset mid-copy: `rst` asserted in the 3rd WRITE of a len=8 copy → next cycle `busy`=0, `mem_wen`=0; only the first 2 (or 3) destination bytes are changed.
